jolt160_imm_exec: RTL and testbench

Registered immediate-execute unit for the Jolt160 CPU. Each cycle it can accept one 16-bit instruction word. It classifies the word into an instruction group and decodes group-1 (register/immediate) fields. For group-1 words it runs the ALU operation on the operand read from the external register file and returns a write-back request and updated processor flags one cycle later. The unit owns the processor flags register; the CPU's register file and sequencer sit outside it.

---
 rtl/jolt160_imm_exec_pkg.sv | 52 +++++
 rtl/jolt160_imm_exec_alu.sv | 64 ++++++
 rtl/jolt160_imm_exec.sv | 106 ++++++++++
 tb/tb_jolt160_imm_exec.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/jolt160_imm_exec_pkg.sv
// Shared types for the Jolt160 immediate-execute unit: group and opcode
// encodings, flag bit positions and the ALU operation set.
package pkg_jolt_imm_exec;

  typedef enum logic [2:0] {
    GRP_UNKNOWN = 3'd0,
    GRP_1       = 3'd1,
    GRP_2       = 3'd2,
    GRP_3       = 3'd3,
    GRP_4       = 3'd4,
    GRP_5       = 3'd5
  } grp_e;

  typedef enum logic [2:0] {
    OP_ADDI  = 3'd0,
    OP_ADCI  = 3'd1,
    OP_SUBI  = 3'd2,
    OP_SBCI  = 3'd3,
    OP_CMPI  = 3'd4,
    OP_ANDI  = 3'd5,
    OP_ORI   = 3'd6,
    OP_ADDPI = 3'd7
  } g1_op_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_ADC   = 3'd1,
    ALU_SUB   = 3'd2,
    ALU_SBC   = 3'd3,
    ALU_AND   = 3'd4,
    ALU_OR    = 3'd5,
    ALU_ADD16 = 3'd6
  } alu_op_e;

  // Group classification of the top nibble of an instruction word.
  function automatic grp_e decode_grp(input logic [3:0] top);
    casez (top)
      4'b0???: decode_grp = GRP_1;
      4'b1000: decode_grp = GRP_2;
      4'b1001: decode_grp = GRP_3;
      4'b1010: decode_grp = GRP_4;
      4'b1011: decode_grp = GRP_5;
      default: decode_grp = GRP_UNKNOWN;
    endcase
  endfunction

endpackage

// File: rtl/jolt160_imm_exec_alu.sv
// Combinational ALU core: 8-bit add/sub with carry, logic ops, and a 16-bit
// add for the register-pair op. Produces the full updated flag nibble.
module jolt_alu_core
  import pkg_jolt_imm_exec::*;
(
  input  alu_op_e    op,
  input  logic [7:0] a_hi,
  input  logic [7:0] a_lo,
  input  logic [7:0] b_hi,
  input  logic [7:0] b_lo,
  input  logic [3:0] flags_in,
  output logic [7:0] out_hi,
  output logic [7:0] out_lo,
  output logic [3:0] flags_out
);

  logic       is_sub;
  logic       cin;
  logic [7:0] b_eff;
  logic [8:0] sum8;
  logic [16:0] sum16;

  // Subtraction is A + ~B + cin; carry-out then means "no borrow".
  always_comb begin
    is_sub = (op == ALU_SUB) || (op == ALU_SBC);
    b_eff  = is_sub ? ~b_lo : b_lo;
    case (op)
      ALU_SUB:          cin = 1'b1;
      ALU_ADC, ALU_SBC: cin = flags_in[FLAG_C];
      default:          cin = 1'b0;
    endcase
    sum8  = {1'b0, a_lo} + {1'b0, b_eff} + {8'd0, cin};
    sum16 = {1'b0, a_hi, a_lo} + {1'b0, b_hi, b_lo};
  end

  // Result and flag selection; logic ops keep C and V.
  always_comb begin
    out_hi    = 8'd0;
    out_lo    = 8'd0;
    flags_out = flags_in;
    case (op)
      ALU_AND, ALU_OR: begin
        out_lo            = (op == ALU_AND) ? (a_lo & b_lo) : (a_lo | b_lo);
        flags_out[FLAG_Z] = (out_lo == 8'd0);
        flags_out[FLAG_N] = out_lo[7];
      end
      ALU_ADD16: begin
        {out_hi, out_lo}  = sum16[15:0];
        flags_out[FLAG_Z] = (sum16[15:0] == 16'd0);
        flags_out[FLAG_C] = sum16[16];
        flags_out[FLAG_V] = (a_hi[7] == b_hi[7]) && (sum16[15] != a_hi[7]);
        flags_out[FLAG_N] = sum16[15];
      end
      default: begin
        out_lo            = sum8[7:0];
        flags_out[FLAG_Z] = (sum8[7:0] == 8'd0);
        flags_out[FLAG_C] = sum8[8];
        flags_out[FLAG_V] = (a_lo[7] == b_eff[7]) && (sum8[7] != a_lo[7]);
        flags_out[FLAG_N] = sum8[7];
      end
    endcase
  end

endmodule

// File: rtl/jolt160_imm_exec.sv
// Jolt160 immediate-execute unit: decodes one word per cycle, executes
// group-1 register/immediate ops and registers write-back plus flags.
module jolt160_imm_exec
  import pkg_jolt_imm_exec::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [15:0] instr_in,
  output logic [3:0]  rd_idx_hi,
  output logic [3:0]  rd_idx_lo,
  input  logic [7:0]  opnd_hi,
  input  logic [7:0]  opnd_lo,
  output logic        res_valid,
  output logic [2:0]  res_grp,
  output logic        res_illegal,
  output logic        wr_en,
  output logic        wr_pair,
  output logic [3:0]  wr_idx,
  output logic [7:0]  res_hi,
  output logic [7:0]  res_lo,
  output logic [3:0]  flags
);

  grp_e       grp;
  g1_op_e     opc;
  logic [3:0] ra;
  logic [7:0] imm8;
  logic       is_pair;
  alu_op_e    alu_op;
  logic [7:0] alu_hi;
  logic [7:0] alu_lo;
  logic [3:0] alu_flags;
  logic [1:0] vld_pipe;

  // Field decode and register-read indices, independent of instr_valid.
  always_comb begin
    grp       = decode_grp(instr_in[15:12]);
    opc       = g1_op_e'(instr_in[14:12]);
    ra        = instr_in[11:8];
    imm8      = instr_in[7:0];
    is_pair   = (opc == OP_ADDPI);
    rd_idx_hi = is_pair ? {ra[3:1], 1'b0} : ra;
    rd_idx_lo = is_pair ? {ra[3:1], 1'b1} : ra;
    case (opc)
      OP_ADDI:          alu_op = ALU_ADD;
      OP_ADCI:          alu_op = ALU_ADC;
      OP_SUBI, OP_CMPI: alu_op = ALU_SUB;
      OP_SBCI:          alu_op = ALU_SBC;
      OP_ANDI:          alu_op = ALU_AND;
      OP_ORI:           alu_op = ALU_OR;
      default:          alu_op = ALU_ADD16;
    endcase
  end

  jolt_alu_core u_alu (
    .op        (alu_op),
    .a_hi      (opnd_hi),
    .a_lo      (opnd_lo),
    .b_hi      (8'd0),
    .b_lo      (imm8),
    .flags_in  (flags),
    .out_hi    (alu_hi),
    .out_lo    (alu_lo),
    .flags_out (alu_flags)
  );

  assign vld_pipe[0] = instr_valid;
  assign res_valid   = vld_pipe[1];

  // Result/flag registers; idle cycles hold everything but the valid pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_pipe[1] <= 1'b0;
      res_grp     <= 3'd0;
      res_illegal <= 1'b0;
      wr_en       <= 1'b0;
      wr_pair     <= 1'b0;
      wr_idx      <= 4'd0;
      res_hi      <= 8'd0;
      res_lo      <= 8'd0;
      flags       <= 4'd0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      if (vld_pipe[0]) begin
        res_grp     <= grp;
        res_illegal <= (grp == GRP_UNKNOWN);
        if (grp == GRP_1) begin
          wr_en   <= (opc != OP_CMPI);
          wr_pair <= is_pair;
          wr_idx  <= is_pair ? {ra[3:1], 1'b0} : ra;
          res_hi  <= alu_hi;
          res_lo  <= alu_lo;
          flags   <= alu_flags;
        end else begin
          wr_en   <= 1'b0;
          wr_pair <= 1'b0;
          wr_idx  <= 4'd0;
          res_hi  <= 8'd0;
          res_lo  <= 8'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_jolt160_imm_exec.sv
// Directed bench for jolt160_imm_exec with hand-computed expectations.
module tb_jolt160_imm_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr_in;
  logic [3:0]  rd_idx_hi, rd_idx_lo;
  logic [7:0]  opnd_hi, opnd_lo;
  logic        res_valid;
  logic [2:0]  res_grp;
  logic        res_illegal, wr_en, wr_pair;
  logic [3:0]  wr_idx;
  logic [7:0]  res_hi, res_lo;
  logic [3:0]  flags;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jolt160_imm_exec dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_in(instr_in),
    .rd_idx_hi(rd_idx_hi), .rd_idx_lo(rd_idx_lo), .opnd_hi(opnd_hi), .opnd_lo(opnd_lo),
    .res_valid(res_valid), .res_grp(res_grp), .res_illegal(res_illegal),
    .wr_en(wr_en), .wr_pair(wr_pair), .wr_idx(wr_idx), .res_hi(res_hi),
    .res_lo(res_lo), .flags(flags)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one word for one edge, then land 1 time unit after the edge.
  task automatic issue(input logic v, input logic [15:0] w, input logic [7:0] hi, input logic [7:0] lo);
    instr_valid = v;
    instr_in    = w;
    opnd_hi     = hi;
    opnd_lo     = lo;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".res_valid"}, {15'd0, res_valid}, 16'd0);
    chk({tag, ".res_grp"}, {13'd0, res_grp}, 16'd0);
    chk({tag, ".res_illegal"}, {15'd0, res_illegal}, 16'd0);
    chk({tag, ".wr_en"}, {15'd0, wr_en}, 16'd0);
    chk({tag, ".wr_pair"}, {15'd0, wr_pair}, 16'd0);
    chk({tag, ".wr_idx"}, {12'd0, wr_idx}, 16'd0);
    chk({tag, ".res"}, {res_hi, res_lo}, 16'h0000);
    chk({tag, ".flags"}, {12'd0, flags}, 16'h0);
  endtask

  initial begin
    reset = 1'b0;
    instr_valid = 1'b0;
    instr_in = 16'h0000;
    opnd_hi = 8'h00;
    opnd_lo = 8'h00;
    @(negedge clk);
    issue(1'b0, 16'h0000, 8'h00, 8'h00);
    chk_all_zero("reset");

    reset = 1'b1;
    // addi r3,1 on 0xFF -> 0x00, Z and C
    issue(1'b1, 16'h0301, 8'h00, 8'hFF);
    chk("addi.valid", {15'd0, res_valid}, 16'd1);
    chk("addi.grp", {13'd0, res_grp}, 16'd1);
    chk("addi.res", {res_hi, res_lo}, 16'h0000);
    chk("addi.wr_idx", {12'd0, wr_idx}, 16'd3);
    chk("addi.wr_en", {14'd0, wr_en, wr_pair}, 16'b10);
    chk("addi.flags", {12'd0, flags}, 16'b0011);

    // adci r1,4 on 0x10 with C=1 -> 0x15
    issue(1'b1, 16'h1104, 8'h00, 8'h10);
    chk("adci.res", {res_hi, res_lo}, 16'h0015);
    chk("adci.flags", {12'd0, flags}, 16'b0000);

    // subi r2,5 on 0x03 -> 0xFE, borrow so C=0, N=1
    instr_in = 16'h2205;
    #1;
    chk("rd8.idx", {8'd0, rd_idx_hi, rd_idx_lo}, 16'h0022);
    issue(1'b1, 16'h2205, 8'h00, 8'h03);
    chk("subi.res", {res_hi, res_lo}, 16'h00FE);
    chk("subi.wr_idx", {12'd0, wr_idx}, 16'd2);
    chk("subi.flags", {12'd0, flags}, 16'b1000);

    // cmpi r2,3 on 0x03: no write, Z and C
    issue(1'b1, 16'h4203, 8'h00, 8'h03);
    chk("cmpi.wr_en", {15'd0, wr_en}, 16'd0);
    chk("cmpi.flags", {12'd0, flags}, 16'b0011);

    // addpi r4:r5 += 0x90: 0x12F0 + 0x0090 = 0x1380
    instr_in = 16'h7590;
    #1;
    chk("pair.rd_idx", {8'd0, rd_idx_hi, rd_idx_lo}, 16'h0045);
    issue(1'b1, 16'h7590, 8'h12, 8'hF0);
    chk("addpi.res", {res_hi, res_lo}, 16'h1380);
    chk("addpi.wr", {12'd0, wr_en, wr_pair, 2'd0}, {12'd0, 4'b1100});
    chk("addpi.wr_idx", {12'd0, wr_idx}, 16'd4);
    chk("addpi.flags", {12'd0, flags}, 16'b0000);

    // idle cycle: valid drops, everything else holds
    issue(1'b0, 16'h0301, 8'h00, 8'hFF);
    chk("idle.valid", {15'd0, res_valid}, 16'd0);
    chk("idle.res", {res_hi, res_lo}, 16'h1380);
    chk("idle.flags", {12'd0, flags}, 16'b0000);

    // non-group-1 words
    issue(1'b1, 16'h8123, 8'hAA, 8'h55);
    chk("g2.valid", {15'd0, res_valid}, 16'd1);
    chk("g2.grp", {13'd0, res_grp}, 16'd2);
    chk("g2.wr_ill", {14'd0, wr_en, res_illegal}, 16'd0);
    chk("g2.res", {res_hi, res_lo}, 16'h0000);
    chk("g2.flags", {12'd0, flags}, 16'b0000);
    issue(1'b1, 16'hC000, 8'h00, 8'h00);
    chk("unk.grp", {13'd0, res_grp}, 16'd0);
    chk("unk.illegal", {15'd0, res_illegal}, 16'd1);
    issue(1'b1, 16'hB000, 8'h00, 8'h00);
    chk("g5.grp", {13'd0, res_grp}, 16'd5);
    chk("g5.illegal", {15'd0, res_illegal}, 16'd0);

    // build C=1, Z=0 then check logic ops preserve C
    issue(1'b1, 16'h0301, 8'h00, 8'hFF);
    chk("setc.flags", {12'd0, flags}, 16'b0011);
    issue(1'b1, 16'h0002, 8'h00, 8'hFF);
    chk("setc2.res", {res_hi, res_lo}, 16'h0001);
    chk("setc2.flags", {12'd0, flags}, 16'b0010);
    issue(1'b1, 16'h50F0, 8'h00, 8'h0F);
    chk("andi.res", {res_hi, res_lo}, 16'h0000);
    chk("andi.flags", {12'd0, flags}, 16'b0011);
    issue(1'b1, 16'h6080, 8'h00, 8'h01);
    chk("ori.res", {res_hi, res_lo}, 16'h0081);
    chk("ori.flags", {12'd0, flags}, 16'b1010);
    // sbci r3,5 on 0x10 with C=1 -> 0x0B, no borrow
    issue(1'b1, 16'h3305, 8'h00, 8'h10);
    chk("sbci.res", {res_hi, res_lo}, 16'h000B);
    chk("sbci.flags", {12'd0, flags}, 16'b0010);
    // addi 0x7F+1 -> signed overflow
    issue(1'b1, 16'h0001, 8'h00, 8'h7F);
    chk("ovf.res", {res_hi, res_lo}, 16'h0080);
    chk("ovf.flags", {12'd0, flags}, 16'b1100);

    // reset wins over a simultaneous valid word
    reset = 1'b0;
    issue(1'b1, 16'h0301, 8'h00, 8'hFF);
    chk_all_zero("rst_valid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
